fetch_decode_queue: RTL and testbench

Decoupling queue between the fetch stage and the decode stage. Each cycle it accepts one fetched instruction tagged with its PC, buffers up to DEPTH entries, and presents them in order to decode with a valid/ready handshake. A flush input discards all buffered entries on a taken branch or PC redirect. Its `inReady` is the fetch-stall signal that holds the PC register.

---
 rtl/asip_pkg.sv | 14 +
 rtl/fetch_decode_queue.sv | 78 +++++++
 tb/tb_fetch_decode_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/asip_pkg.sv
// Shared types and widths for the fetch/decode datapath.
package asip_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode decoupling queue: in-order buffer of {pc, instr} with flush.
// inReady depends only on registered occupancy, so it can stall the fetch PC.
module fetch_decode_queue #(
  parameter int unsigned PC_W    = asip_pkg::PC_W,
  parameter int unsigned INSTR_W = asip_pkg::INSTR_W,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     inValid,
  input  logic [PC_W-1:0]          inPc,
  input  logic [INSTR_W-1:0]       inInstr,
  output logic                     inReady,
  output logic                     outValid,
  output logic [PC_W-1:0]          outPc,
  output logic [INSTR_W-1:0]       outInstr,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   count
);
  import asip_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_pkt_t       r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  fetch_pkt_t       w_head_pkt;

  assign inReady    = (r_count != CW'(DEPTH));
  assign outValid   = (r_count != '0);
  assign count      = r_count;

  // Flush wins over push; a pop in the flush cycle is simply absorbed by the clear.
  assign w_push     = inValid && inReady && !flush;
  assign w_pop      = outValid && outReady;

  assign w_head_pkt = r_mem[r_head];
  assign outPc      = outValid ? w_head_pkt.pc    : '0;
  assign outInstr   = outValid ? w_head_pkt.instr : NOP_INSTR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= {inPc, inInstr};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    r_count <= CW'(DEPTH));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    (r_count == '0) |-> !w_pop);

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic [7:0]  inPc;
  logic [15:0] inInstr;
  logic        inReady;
  logic        outValid;
  logic [7:0]  outPc;
  logic [15:0] outInstr;
  logic        outReady;
  logic [1:0]  count;

  fetch_decode_queue #(.PC_W(8), .INSTR_W(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .inValid  (inValid),
    .inPc     (inPc),
    .inInstr  (inInstr),
    .inReady  (inReady),
    .outValid (outValid),
    .outPc    (outPc),
    .outInstr (outInstr),
    .outReady (outReady),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] popped[$];
  int         vectors     = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs against what the reference queue implies.
  task automatic compare();
    int unsigned n;
    n = mq.size();
    chk("count",    32'(count),    n);
    chk("inReady",  32'(inReady),  32'(n != DEPTH));
    chk("outValid", 32'(outValid), 32'(n != 0));
    chk("outPc",    32'(outPc),    (n != 0) ? 32'(mq[0].pc)    : 32'h0);
    chk("outInstr", 32'(outInstr), (n != 0) ? 32'(mq[0].instr) : 32'h0);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at the falling edge.
  task automatic cyc(input logic v, input logic [7:0] pc, input logic [15:0] ins,
                     input logic rdy, input logic fl);
    bit do_push;
    inValid  = v;
    inPc     = pc;
    inInstr  = ins;
    outReady = rdy;
    flush    = fl;
    #1;
    if (outValid && rdy) popped.push_back(outPc);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      do_push = v && (mq.size() < DEPTH);
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc, ins});
    end
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; inValid = 1'b0; inPc = '0; inInstr = '0; outReady = 1'b0;
    @(negedge clk);
    compare();
    chk("rst_inReady", 32'(inReady), 32'h1);
    reset = 1'b1;

    // Reset mid-stream
    cyc(1'b1, 8'h00, 16'hAAAA, 1'b0, 1'b0);
    cyc(1'b1, 8'h04, 16'hBBBB, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'h2);
    chk("full_inReady", 32'(inReady), 32'h0);
    #2 reset = 1'b0;
    #1 mq.delete();
    compare();
    chk("midrst_outValid", 32'(outValid), 32'h0);
    chk("midrst_outInstr", 32'(outInstr), 32'h0);
    chk("midrst_count",    32'(count),    32'h0);
    chk("midrst_inReady",  32'(inReady),  32'h1);
    @(negedge clk);
    reset = 1'b1;

    // Streaming at one entry per cycle
    cyc(1'b1, 8'h00, 16'h1111, 1'b1, 1'b0);
    chk("stream0_pc", 32'(outPc), 32'h00);
    cyc(1'b1, 8'h04, 16'h2222, 1'b1, 1'b0);
    chk("stream1_pc", 32'(outPc), 32'h04);
    chk("stream1_count", 32'(count), 32'h1);
    cyc(1'b1, 8'h08, 16'h3333, 1'b1, 1'b0);
    chk("stream2_instr", 32'(outInstr), 32'h3333);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);

    // Full / backpressure
    cyc(1'b1, 8'h10, 16'h1010, 1'b0, 1'b0);
    cyc(1'b1, 8'h14, 16'h1414, 1'b0, 1'b0);
    chk("bp_inReady", 32'(inReady), 32'h0);
    cyc(1'b1, 8'h18, 16'h1818, 1'b0, 1'b0);
    chk("bp_head", 32'(outPc), 32'h10);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    chk("bp_pop_head", 32'(outPc), 32'h14);
    chk("bp_pop_inReady", 32'(inReady), 32'h1);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);

    // Wrap-around with mixed stalls
    popped.delete();
    cyc(1'b1, 8'h50, 16'h5050, 1'b0, 1'b0);
    cyc(1'b1, 8'h54, 16'h5454, 1'b1, 1'b0);
    cyc(1'b1, 8'h58, 16'h5858, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 8'h5C, 16'h5C5C, 1'b1, 1'b0);
    cyc(1'b1, 8'h60, 16'h6060, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    chk("wrap_npop", 32'(popped.size()), 32'd5);
    begin
      logic [7:0] exp_pcs [5];
      exp_pcs = '{8'h50, 8'h54, 8'h58, 8'h5C, 8'h60};
      for (int i = 0; i < 5; i++)
        chk($sformatf("wrap_pc%0d", i),
            (i < popped.size()) ? 32'(popped[i]) : 32'hFFFF_FFFF, 32'(exp_pcs[i]));
    end

    // Flush with a push in the flush cycle
    cyc(1'b1, 8'h20, 16'h2020, 1'b0, 1'b0);
    cyc(1'b1, 8'h24, 16'h2424, 1'b0, 1'b0);
    cyc(1'b1, 8'h28, 16'h2828, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_outValid", 32'(outValid), 32'h0);
    cyc(1'b1, 8'h40, 16'h4040, 1'b0, 1'b0);
    chk("postflush_head", 32'(outPc), 32'h40);
    chk("postflush_count", 32'(count), 32'h1);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);

    // Simultaneous push and pop at count=1
    cyc(1'b1, 8'h30, 16'h3030, 1'b0, 1'b0);
    cyc(1'b1, 8'h34, 16'h3434, 1'b1, 1'b0);
    chk("pp_head", 32'(outPc), 32'h34);
    chk("pp_count", 32'(count), 32'h1);
    cyc(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
